// File: rtl/platform_gen.sv
// Platform field generator: owns the N platform positions, scrolls them down
// behind a climbing doodle and respawns platforms that leave the bottom edge.
module platform_gen #(
  parameter int          W             = 640,
  parameter int          H             = 480,
  parameter int          X_MIN         = 140,
  parameter int          X_MAX         = 499,
  parameter int          PLATFORM_SIZE = 60,
  parameter int          N             = 8,
  parameter int          SPACING       = 60,
  parameter int          SCROLL_LINE   = 160,
  parameter int          DY_MAX        = 8,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  frame_clk_edge,
  input  logic [7:0]  state,
  input  logic [9:0]  Doodle_Y_in,
  output logic [9:0]  Platform_X [0:N-1],
  output logic [9:0]  Platform_Y [0:N-1],
  output logic [9:0]  scroll_dy,
  output logic [15:0] score,
  output logic        busy,
  output logic        frame_done
);

  localparam int IW          = (N > 1) ? $clog2(N) : 1;
  localparam int LAYOUT_Y0   = 460;
  localparam int LAYOUT_DX   = 40;
  // Respawn range is also clipped so a platform can never hang off screen.
  localparam int SPAN_PLAY   = X_MAX - X_MIN - PLATFORM_SIZE + 1;
  localparam int SPAN_SCREEN = W - PLATFORM_SIZE - X_MIN + 1;
  localparam int X_SPAN      = (SPAN_PLAY < SPAN_SCREEN) ? SPAN_PLAY : SPAN_SCREEN;

  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic [9:0]    H_V      = 10'(H);
  localparam logic [9:0]    SCROLL_V = 10'(SCROLL_LINE);
  localparam logic [9:0]    DYMAX_V  = 10'(DY_MAX);
  localparam logic [9:0]    XMIN_V   = 10'(X_MIN);
  localparam logic [8:0]    SPAN_V   = 9'(X_SPAN);

  typedef enum logic [1:0] {IDLE, SCROLL, RESPAWN, COMMIT} fsm_t;

  fsm_t          fsm_q, fsm_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [9:0]    dy_q, dy_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [15:0]   score_q, score_d;
  logic [9:0]    scroll_dy_q, scroll_dy_d;
  logic          frame_done_q, frame_done_d;
  logic [9:0]    wx_q [0:N-1];
  logic [9:0]    wx_d [0:N-1];
  logic [9:0]    wy_q [0:N-1];
  logic [9:0]    wy_d [0:N-1];
  logic [9:0]    px_q [0:N-1];
  logic [9:0]    px_d [0:N-1];
  logic [9:0]    py_q [0:N-1];
  logic [9:0]    py_d [0:N-1];
  logic          tick;

  function automatic logic [9:0] layout_x(input int i);
    return 10'(X_MIN + LAYOUT_DX * i);
  endfunction

  function automatic logic [9:0] layout_y(input int i);
    return 10'(LAYOUT_Y0 - SPACING * i);
  endfunction

  function automatic logic [9:0] calc_dy(input logic [9:0] y);
    logic [9:0] diff;
    diff = SCROLL_V - y;
    if (y >= SCROLL_V)     return 10'd0;
    else if (diff > DYMAX_V) return DYMAX_V;
    else                     return diff;
  endfunction

  function automatic logic [9:0] respawn_x(input logic [8:0] r_raw);
    logic [8:0] r;
    r = r_raw;
    if (r >= SPAN_V) r = r - SPAN_V;
    return XMIN_V + {1'b0, r};
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] s);
    return (s == 16'hFFFF) ? s : s + 16'd1;
  endfunction

  assign tick = (frame_clk_edge == 2'b01);

  always_comb begin
    fsm_d        = fsm_q;
    idx_d        = idx_q;
    dy_d         = dy_q;
    lfsr_d       = lfsr_q;
    score_d      = score_q;
    scroll_dy_d  = scroll_dy_q;
    frame_done_d = 1'b0;
    wx_d         = wx_q;
    wy_d         = wy_q;
    px_d         = px_q;
    py_d         = py_q;
    case (fsm_q)
      IDLE: begin
        if (tick) begin
          if (state == 8'd0) begin
            for (int i = 0; i < N; i++) begin
              wx_d[i] = layout_x(i);
              wy_d[i] = layout_y(i);
              px_d[i] = layout_x(i);
              py_d[i] = layout_y(i);
            end
            scroll_dy_d = 10'd0;
          end else if (state == 8'd1) begin
            dy_d  = calc_dy(Doodle_Y_in);
            idx_d = '0;
            fsm_d = SCROLL;
          end
        end
      end
      SCROLL: begin
        wy_d[idx_q] = wy_q[idx_q] + dy_q;
        if (idx_q == IDX_LAST) begin
          idx_d = '0;
          fsm_d = RESPAWN;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      RESPAWN: begin
        if (wy_q[idx_q] >= H_V) begin
          wy_d[idx_q] = wy_q[idx_q] - H_V;
          wx_d[idx_q] = respawn_x(lfsr_q[8:0]);
          lfsr_d      = lfsr_next(lfsr_q);
          score_d     = sat_inc(score_q);
        end
        if (idx_q == IDX_LAST) begin
          idx_d = '0;
          fsm_d = COMMIT;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      COMMIT: begin
        // Whole-field copy in one cycle so consumers never see a partial frame.
        px_d         = wx_q;
        py_d         = wy_q;
        scroll_dy_d  = dy_q;
        frame_done_d = 1'b1;
        fsm_d        = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fsm_q        <= IDLE;
      idx_q        <= '0;
      dy_q         <= 10'd0;
      lfsr_q       <= LFSR_SEED;
      score_q      <= 16'd0;
      scroll_dy_q  <= 10'd0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        wx_q[i] <= layout_x(i);
        wy_q[i] <= layout_y(i);
        px_q[i] <= layout_x(i);
        py_q[i] <= layout_y(i);
      end
    end else begin
      fsm_q        <= fsm_d;
      idx_q        <= idx_d;
      dy_q         <= dy_d;
      lfsr_q       <= lfsr_d;
      score_q      <= score_d;
      scroll_dy_q  <= scroll_dy_d;
      frame_done_q <= frame_done_d;
      wx_q         <= wx_d;
      wy_q         <= wy_d;
      px_q         <= px_d;
      py_q         <= py_d;
    end
  end

  assign Platform_X = px_q;
  assign Platform_Y = py_q;
  assign scroll_dy  = scroll_dy_q;
  assign score      = score_q;
  assign busy       = (fsm_q != IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_platform_gen.sv
// Bench for platform_gen: frame-level reference model of scroll/respawn rules
// compared against the committed platform field, score and frame timing.
module tb_platform_gen;
  localparam int N = 8;

  logic        Clk;
  logic        Reset;
  logic [1:0]  frame_clk_edge;
  logic [7:0]  state;
  logic [9:0]  Doodle_Y_in;
  logic [9:0]  px [0:N-1];
  logic [9:0]  py [0:N-1];
  logic [9:0]  scroll_dy;
  logic [15:0] score;
  logic        busy;
  logic        frame_done;

  platform_gen dut (
    .Clk(Clk), .Reset(Reset), .frame_clk_edge(frame_clk_edge), .state(state),
    .Doodle_Y_in(Doodle_Y_in), .Platform_X(px), .Platform_Y(py),
    .scroll_dy(scroll_dy), .score(score), .busy(busy), .frame_done(frame_done)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model of the playfield.
  int          mx [N];
  int          my [N];
  logic [15:0] mlfsr;
  int          mscore;
  int          msdy;

  // Observations from the last play() call.
  int          busy_cnt, busy_first, done_at, done_cnt;
  logic [9:0]  snap_x [N];
  logic [9:0]  snap_y [N];
  logic [9:0]  snap_sdy;
  logic [15:0] snap_score;
  logic        snap_busy;

  task automatic model_layout();
    for (int i = 0; i < N; i++) begin
      mx[i] = 140 + 40 * i;
      my[i] = 460 - 60 * i;
    end
    msdy = 0;
  endtask

  task automatic model_reset();
    model_layout();
    mlfsr  = 16'hACE1;
    mscore = 0;
  endtask

  task automatic model_play(input int st, input int doodle);
    int dy, r;
    if (st == 0) begin
      model_layout();
    end else if (st == 1) begin
      dy = 0;
      if (doodle < 160) dy = (160 - doodle > 8) ? 8 : 160 - doodle;
      for (int i = 0; i < N; i++) my[i] += dy;
      for (int i = 0; i < N; i++) begin
        if (my[i] >= 480) begin
          my[i] -= 480;
          r = mlfsr % 512;
          if (r >= 300) r -= 300;
          mx[i] = 140 + r;
          mlfsr = {1'b0, mlfsr[15:1]} ^ (mlfsr[0] ? 16'hB400 : 16'h0000);
          if (mscore < 65535) mscore++;
        end
      end
      msdy = dy;
    end
  endtask

  task automatic do_reset(input int n);
    Reset = 1'b1;
    repeat (n) @(posedge Clk);
    #1;
    Reset = 1'b0;
    model_reset();
  endtask

  // Issues one tick and watches 30 cycles; optional second tick while busy.
  task automatic play(input logic [7:0] st, input logic [9:0] dyin, input int extra_tick_at);
    state          = st;
    Doodle_Y_in    = dyin;
    frame_clk_edge = 2'b01;
    @(posedge Clk);
    #1;
    frame_clk_edge = 2'b00;
    busy_cnt = 0; busy_first = -1; done_at = -1; done_cnt = 0; snap_busy = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (busy === 1'b1) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = k;
      end
      if (frame_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          snap_x = px; snap_y = py;
          snap_sdy = scroll_dy; snap_score = score; snap_busy = busy;
        end
      end
      if (k == extra_tick_at) frame_clk_edge = 2'b01;
      @(posedge Clk);
      #1;
      frame_clk_edge = 2'b00;
    end
  endtask

  task automatic test_reset();
    do_reset(2);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (px[i] !== 10'(mx[i]) || py[i] !== 10'(my[i])) begin
        errors++;
        $display("FAIL reset_layout plat%0d X=%0d Y=%0d expected X=%0d Y=%0d", i, px[i], py[i], mx[i], my[i]);
      end
    end
    checks++;
    if (score !== 16'd0 || busy !== 1'b0 || scroll_dy !== 10'd0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl score=%0d busy=%b sdy=%0d done=%b expected 0 0 0 0", score, busy, scroll_dy, frame_done);
    end
  endtask

  task automatic test_no_scroll();
    play(8'd1, 10'd200, -1);
    model_play(1, 200);
    checks++;
    if (busy_first != 1 || busy_cnt != 17) begin
      errors++;
      $display("FAIL busy_window first=%0d count=%0d expected first=1 count=17", busy_first, busy_cnt);
    end
    checks++;
    if (done_at != 18 || done_cnt != 1 || snap_busy !== 1'b0) begin
      errors++;
      $display("FAIL done_timing at=%0d count=%0d busy=%b expected at=18 count=1 busy=0", done_at, done_cnt, snap_busy);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (snap_x[i] !== 10'(mx[i]) || snap_y[i] !== 10'(my[i])) begin
        errors++;
        $display("FAIL no_scroll plat%0d X=%0d Y=%0d expected X=%0d Y=%0d", i, snap_x[i], snap_y[i], mx[i], my[i]);
      end
    end
    checks++;
    if (snap_sdy !== 10'd0) begin
      errors++;
      $display("FAIL no_scroll_dy got=%0d expected=0", snap_sdy);
    end
  endtask

  task automatic test_scroll();
    play(8'd1, 10'd155, -1);
    model_play(1, 155);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (snap_x[i] !== 10'(mx[i]) || snap_y[i] !== 10'(my[i])) begin
        errors++;
        $display("FAIL scroll plat%0d X=%0d Y=%0d expected X=%0d Y=%0d", i, snap_x[i], snap_y[i], mx[i], my[i]);
      end
    end
    checks++;
    if (snap_y[0] !== 10'd465 || snap_y[7] !== 10'd45 || snap_sdy !== 10'd5 || snap_score !== 16'd0) begin
      errors++;
      $display("FAIL scroll_vals Y0=%0d Y7=%0d sdy=%0d score=%0d expected 465 45 5 0", snap_y[0], snap_y[7], snap_sdy, snap_score);
    end
  endtask

  task automatic test_cap_respawn();
    do_reset(2);
    for (int f = 0; f < 3; f++) begin
      play(8'd1, 10'd100, -1);
      model_play(1, 100);
      checks++;
      if (done_cnt != 1 || snap_sdy !== 10'd8) begin
        errors++;
        $display("FAIL cap_frame%0d done_count=%0d sdy=%0d expected 1 8", f, done_cnt, snap_sdy);
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (snap_x[i] !== 10'(mx[i]) || snap_y[i] !== 10'(my[i])) begin
        errors++;
        $display("FAIL cap_respawn plat%0d X=%0d Y=%0d expected X=%0d Y=%0d", i, snap_x[i], snap_y[i], mx[i], my[i]);
      end
    end
    checks++;
    if (snap_y[0] !== 10'd4 || snap_x[0] !== 10'd365 || snap_y[1] !== 10'd424 || snap_score !== 16'd1) begin
      errors++;
      $display("FAIL respawn_vals Y0=%0d X0=%0d Y1=%0d score=%0d expected 4 365 424 1", snap_y[0], snap_x[0], snap_y[1], snap_score);
    end
  endtask

  task automatic test_reload();
    play(8'd0, 10'd100, -1);
    model_play(0, 100);
    checks++;
    if (done_cnt != 0 || busy_first != -1) begin
      errors++;
      $display("FAIL reload_ctrl done_count=%0d busy_first=%0d expected 0 -1", done_cnt, busy_first);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (px[i] !== 10'(mx[i]) || py[i] !== 10'(my[i])) begin
        errors++;
        $display("FAIL reload plat%0d X=%0d Y=%0d expected X=%0d Y=%0d", i, px[i], py[i], mx[i], my[i]);
      end
    end
    checks++;
    if (score !== 16'd1 || scroll_dy !== 10'd0) begin
      errors++;
      $display("FAIL reload_keep score=%0d sdy=%0d expected 1 0", score, scroll_dy);
    end
    // LFSR must have kept 0xE270, so the next respawn lands at 140 + 0x070.
    for (int f = 0; f < 3; f++) begin
      play(8'd1, 10'd100, -1);
      model_play(1, 100);
    end
    checks++;
    if (snap_x[0] !== 10'd252 || snap_y[0] !== 10'd4 || snap_score !== 16'd2 || snap_x[0] !== 10'(mx[0])) begin
      errors++;
      $display("FAIL lfsr_kept X0=%0d Y0=%0d score=%0d expected 252 4 2", snap_x[0], snap_y[0], snap_score);
    end
  endtask

  task automatic test_busy_tick();
    play(8'd1, 10'd150, 5);
    model_play(1, 150);
    checks++;
    if (done_cnt != 1 || busy_cnt != 17 || done_at != 18) begin
      errors++;
      $display("FAIL busy_tick done_count=%0d busy=%0d at=%0d expected 1 17 18", done_cnt, busy_cnt, done_at);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (px[i] !== 10'(mx[i]) || py[i] !== 10'(my[i])) begin
        errors++;
        $display("FAIL busy_tick plat%0d X=%0d Y=%0d expected X=%0d Y=%0d", i, px[i], py[i], mx[i], my[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    state          = 8'd1;
    Doodle_Y_in    = 10'd120;
    frame_clk_edge = 2'b01;
    @(posedge Clk);
    #1;
    frame_clk_edge = 2'b00;
    repeat (3) begin
      @(posedge Clk);
      #1;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got=%b expected=1", busy);
    end
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    model_reset();
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || score !== 16'd0 || scroll_dy !== 10'd0) begin
      errors++;
      $display("FAIL mid_reset_ctrl busy=%b done=%b score=%0d sdy=%0d expected 0 0 0 0", busy, frame_done, score, scroll_dy);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (px[i] !== 10'(mx[i]) || py[i] !== 10'(my[i])) begin
        errors++;
        $display("FAIL mid_reset plat%0d X=%0d Y=%0d expected X=%0d Y=%0d", i, px[i], py[i], mx[i], my[i]);
      end
    end
    dones = 0;
    for (int k = 0; k < 25; k++) begin
      if (frame_done === 1'b1 || busy === 1'b1) dones++;
      @(posedge Clk);
      #1;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL mid_reset_quiet active_cycles=%0d expected=0", dones);
    end
  endtask

  task automatic test_random();
    int u, st, dyin;
    for (int f = 0; f < 40; f++) begin
      u = $urandom_range(0, 9);
      st = (u == 0) ? 0 : (u == 1) ? $urandom_range(2, 255) : 1;
      dyin = ($urandom_range(0, 1) == 0) ? $urandom_range(100, 170) : $urandom_range(0, 1023);
      play(8'(st), 10'(dyin), -1);
      model_play(st, dyin);
      checks++;
      if (done_cnt != ((st == 1) ? 1 : 0)) begin
        errors++;
        $display("FAIL rand%0d_done st=%0d count=%0d expected=%0d", f, st, done_cnt, (st == 1) ? 1 : 0);
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (px[i] !== 10'(mx[i]) || py[i] !== 10'(my[i])) begin
          errors++;
          $display("FAIL rand%0d plat%0d X=%0d Y=%0d expected X=%0d Y=%0d", f, i, px[i], py[i], mx[i], my[i]);
        end
      end
      checks++;
      if (score !== 16'(mscore) || scroll_dy !== 10'(msdy)) begin
        errors++;
        $display("FAIL rand%0d_stat score=%0d sdy=%0d expected %0d %0d", f, score, scroll_dy, mscore, msdy);
      end
    end
  endtask

  initial begin
    Reset          = 1'b1;
    frame_clk_edge = 2'b00;
    state          = 8'd0;
    Doodle_Y_in    = 10'd0;
    test_reset();
    test_no_scroll();
    test_scroll();
    test_cap_respawn();
    test_reload();
    test_busy_tick();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/platform_gen.md
Name: platform_gen

Overview:
- Producer of the platform field that the doodle physics block consumes.
- Owns the 8 platform positions; drives them on Platform_X/Platform_Y arrays.
- Scrolls the field down when the doodle climbs above a scroll line, then respawns platforms that fall off the bottom at the top, using a 16-bit LFSR for X.
- Updates the positions atomically once per frame tick, well before the next tick.

Parameters:
- W, 640, screen width.
- H, 480, screen height; a platform with Y >= H has left the screen.
- X_MIN, 140, leftmost platform X.
- X_MAX, 499, rightmost playfield X.
- PLATFORM_SIZE, 60, platform width in pixels.
- N, 8, number of platforms.
- SPACING, 60, vertical pitch of the reset layout; N*SPACING = H.
- SCROLL_LINE, 160, doodle Y above which the field scrolls.
- DY_MAX, 8, maximum scroll per frame.
- LFSR_SEED, 16'hACE1, LFSR reset value.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-high reset.
- frame_clk_edge  in  2  frame clock edge code; 2'b01 = frame tick.
- state  in  8  game state: 0 = menu, 1 = playing, other = paused.
- Doodle_Y_in  in  10  current doodle Y, top-left corner.
- Platform_X  out  10 x [0:N-1]  platform left X, registered.
- Platform_Y  out  10 x [0:N-1]  platform top Y, registered.
- scroll_dy  out  10  scroll applied by the last committed frame.
- score  out  16  count of respawned platforms.
- busy  out  1  high while a frame update is in progress.
- frame_done  out  1  one-cycle pulse when outputs commit.

Behaviour:
- Reset and the layout reload (reset-only items marked):
  - Working and output Y[i] = 460 - i*SPACING, giving 460, 400, ..., 40.
  - X[i] = X_MIN + 40*i, giving 140, 180, ..., 420.
  - scroll_dy = 0, busy = 0, frame_done = 0, FSM = IDLE.
  - Reset only: LFSR = LFSR_SEED and score = 0. The reload leaves both untouched.
  - Reset wins over everything, including mid-operation; the outputs show the reset layout the cycle after Reset is sampled.
- FSM states: IDLE -> SCROLL -> RESPAWN -> COMMIT -> IDLE.
- IDLE, on a frame tick (frame_clk_edge == 2'b01):
  - state == 0: reload layout, stay in IDLE, no frame_done.
  - state == 1:
    - dy = min(SCROLL_LINE - Doodle_Y_in, DY_MAX) if Doodle_Y_in < SCROLL_LINE, else 0.
    - Register dy, set idx = 0, go to SCROLL.
  - Other state: ignore the tick.
- SCROLL: one platform per cycle. Working Y[idx] += dy using unsigned 10-bit addition; max 487, so there is no overflow. idx runs 0..N-1, then go to RESPAWN with idx = 0.
- RESPAWN: one platform per cycle. If working Y[idx] >= H:
  - Y[idx] = Y[idx] - H.
  - r = LFSR[8:0]; if r >= 300 then r -= 300. Here 300 = X_MAX - X_MIN - PLATFORM_SIZE + 1.
  - X[idx] = X_MIN + r.
  - LFSR advances once.
  - score += 1, saturating at 16'hFFFF.
  - Otherwise there is no change and no LFSR advance. After idx N-1, go to COMMIT.
- LFSR rule: Galois right shift, next = (L >> 1) ^ (L[0] ? 16'hB400 : 0). It advances only on respawn.
- COMMIT:
  - Copy all working X/Y into the Platform_X/Platform_Y registers in the same cycle, so the arrays never show a partial frame.
  - scroll_dy = dy; pulse frame_done; go to IDLE.
- Timing:
  - Tick sampled at cycle t; busy is high t+1 .. t+2N+1.
  - New outputs and frame_done are visible at t+2N+2, which is t+18 for N = 8.
  - dy = 0 frames still traverse the FSM and pulse frame_done.
- A frame tick while busy is ignored; it is not queued.
- Doodle_Y_in and state are sampled only on the accepted tick in IDLE.
- Out-of-range Doodle_Y_in (> H) gives dy = 0.

Test Plan:
1. Assert Reset 2 cycles -> Y = 460, 400, ..., 40; X = 140, 180, ..., 420; score = 0; busy = 0; scroll_dy = 0.
2. state = 1, Doodle_Y_in = 200, one tick -> busy for 17 cycles; frame_done at t+18; positions unchanged; scroll_dy = 0.
3. Doodle_Y_in = 155, one tick -> all Y +5 (465, 405, ..., 45); scroll_dy = 5; score = 0.
4. Doodle_Y_in = 100, three ticks -> dy capped at 8.
   - Platform 0 goes 468, 476, then 484 >= 480 and respawns.
   - Result: Y[0] = 4, X[0] = 140 + 0x0E1 = 365, LFSR = 0xE270, score = 1. The other Y are +24.
5. Tick issued at t+5 while busy -> ignored; a single frame_done. Reset asserted during SCROLL -> reset layout and busy = 0 next cycle; no frame_done.
6. After the test-4 state, state = 0 and a tick -> layout reloaded. score stays 1, LFSR stays 0xE270, and no frame_done is pulsed.
